inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  IF-stage producer for the IF/ID pipeline register: owns the PC and fetches each instruction over a Wishbone-style bus.
//  Drives if_pc/if_inst into IF/ID and raises stallreq to ctrl while a fetch is outstanding.
//  Obeys the same stall[5:0]/flush vector that IF/ID consumes, so PC, bus cycle and IF/ID stay consistent.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded by reset
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  rst              in   1   asynchronous reset, active-high
//  stall            in   6   ctrl stall vector; [0]=PC hold, [1]=IF/ID hold
//  flush            in   1   exception flush; redirects PC to new_pc
//  new_pc           in   32  exception handler address, used on flush
//  branch_flag_i    in   1   ID resolved a taken branch/jump
//  branch_target_i  in   32  branch/jump target
//  if_pc            out  32  PC of instruction presented on if_inst
//  if_inst          out  32  fetched instruction (0 = nop when none valid)
//  stallreq         out  1   IF requests pipeline stall (fetch pending)
//  iwb_adr_o        out  32  bus address
//  iwb_dat_i        in   32  bus read data
//  iwb_ack_i        in   1   bus acknowledge
//  iwb_cyc_o        out  1   bus cycle
//  iwb_stb_o        out  1   bus strobe
//  iwb_we_o         out  1   constant 0 (read-only master)
//  iwb_sel_o        out  4   constant 4'hF
// BEHAVIOUR
//  Reset (async, immediate): pc=RESET_PC, ce=0, state=IDLE, cyc/stb=0, adr=0, rd_buf=0; outputs if_pc=RESET_PC, if_inst=0, stallreq=0.
//  ce: set to 1 on the first clock edge after rst deasserts; no fetch while ce=0.
//  PC update (posedge, ce=1), priority order:
//   flush=1 -> pc<=new_pc; else stall[0]=0 & branch_flag_i -> pc<=branch_target_i;
//   else stall[0]=0 -> pc<=pc+4 (32-bit modulo, 0xFFFFFFFC wraps to 0); else hold.
//  if_pc = pc (registered).
//  FSM states IDLE, BUSY, WAIT_FOR_STALL:
//   IDLE: if ce & !flush -> cyc/stb<=1, adr<=pc, go BUSY; stallreq=1 (comb.) during this cycle; if_inst=0.
//   BUSY: flush=1 -> cyc/stb<=0, go IDLE, data/ack discarded (flush beats same-cycle ack); stallreq=0.
//         ack=0 -> hold cyc/stb/adr; stallreq=1; if_inst=0.
//         ack=1 -> cyc/stb<=0, rd_buf<=iwb_dat_i, if_inst=iwb_dat_i (comb. pass-through), stallreq=0;
//                  next state WAIT_FOR_STALL if stall[1]=1, else IDLE.
//   WAIT_FOR_STALL: if_inst=rd_buf, stallreq=0, no bus activity; go IDLE when stall[1]=0 or flush=1.
//  Min throughput: 2 cycles/instruction with zero-wait slave (issue cycle + ack cycle).
//  Bus rules: cyc_o==stb_o always; adr stable while stb=1; no new request until prior ack/abort; ack outside BUSY ignored.
//  Flush in IDLE suppresses the issue that cycle; next issue uses new_pc.
//  Reset mid-cycle drops cyc/stb immediately (abort); a later ack is ignored.
// TESTING
//  1 Reset: rst=1 mid-BUSY -> cyc/stb=0 same cycle, if_pc=0, if_inst=0, stallreq=0; after release first request adr=0x0 on 2nd edge.
//  2 Zero-wait memory, stall=0: adr sequence 0x0,0x4,0x8; if_inst equals mem word in each ack cycle; stallreq 1/0 alternating.
//  3 stall=6'b000011 at ack of 0x24020005 -> WAIT_FOR_STALL, if_inst holds 0x24020005, no stb until stall=0, then adr=pc+4.
//  4 flush with new_pc=0x40 during BUSY (ack same cycle) -> ack data dropped, cyc=0 next edge, next request adr=0x40.
//  5 branch_flag_i=1, branch_target_i=0x100 in ack cycle -> next request adr=0x100.
//  6 pc=0xFFFFFFFC acked, stall=0 -> next request adr=0x00000000; 3-wait-state slave -> stallreq held 1 for 3 cycles, adr stable.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
// Instruction-side Wishbone-style read bus between the fetch unit (master) and instruction memory (slave).
// Single outstanding read; cyc and stb always move together.
interface inst_fetch_unit_if;
    logic [31:0] iwb_adr;
    logic [31:0] iwb_dat;
    logic        iwb_ack;
    logic        iwb_cyc;
    logic        iwb_stb;
    logic        iwb_we;
    logic [3:0]  iwb_sel;

    modport master (
        output iwb_adr,
        output iwb_cyc,
        output iwb_stb,
        output iwb_we,
        output iwb_sel,
        input  iwb_dat,
        input  iwb_ack
    );

    modport slave (
        input  iwb_adr,
        input  iwb_cyc,
        input  iwb_stb,
        input  iwb_we,
        input  iwb_sel,
        output iwb_dat,
        output iwb_ack
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// IF stage: owns the PC, fetches one instruction per bus read, presents if_pc/if_inst to IF/ID; 2 cycles/instr minimum.
// Backpressure: stall[0] holds the PC, stall[1] parks a fetched word in WAIT_FOR_STALL; stallreq is high while a fetch is pending.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [5:0]                i_stall,
    input  logic                      i_flush,
    input  logic [31:0]               i_new_pc,
    input  logic                      i_branch_flag,
    input  logic [31:0]               i_branch_target,
    output logic [31:0]               o_if_pc,
    output logic [31:0]               o_if_inst,
    output logic                      o_stallreq,
    inst_fetch_unit_if.master         iwb
);

    typedef enum logic [1:0] {
        ST_IDLE           = 2'd0,
        ST_BUSY           = 2'd1,
        ST_WAIT_FOR_STALL = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic        r_ce;
    logic        r_cyc;
    logic [31:0] r_adr;
    logic [31:0] r_rd_buf;

    logic        w_cyc_nxt;
    logic [31:0] w_adr_nxt;
    logic [31:0] w_rd_buf_nxt;
    logic        w_pc_hold;
    logic        w_unused_stall;

    // Upper stall bits belong to later stages.
    assign w_unused_stall = ^i_stall[5:2];
    assign w_pc_hold      = i_stall[0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ce <= 1'b0;
        end else begin
            r_ce <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (r_ce) begin
            if (i_flush) begin
                r_pc <= i_new_pc;
            end else if (!w_pc_hold && i_branch_flag) begin
                r_pc <= i_branch_target;
            end else if (!w_pc_hold) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cyc    <= 1'b0;
            r_adr    <= 32'h0;
            r_rd_buf <= 32'h0;
        end else begin
            r_state  <= w_state_nxt;
            r_cyc    <= w_cyc_nxt;
            r_adr    <= w_adr_nxt;
            r_rd_buf <= w_rd_buf_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cyc_nxt    = r_cyc;
        w_adr_nxt    = r_adr;
        w_rd_buf_nxt = r_rd_buf;
        o_if_inst    = 32'h0;
        o_stallreq   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_ce && !i_flush) begin
                    w_cyc_nxt   = 1'b1;
                    w_adr_nxt   = r_pc;
                    w_state_nxt = ST_BUSY;
                    o_stallreq  = 1'b1;
                end
            end
            ST_BUSY: begin
                // A flush wins over a same-cycle ack: the returning word is stale.
                if (i_flush) begin
                    w_cyc_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (!iwb.iwb_ack) begin
                    o_stallreq  = 1'b1;
                end else begin
                    w_cyc_nxt    = 1'b0;
                    w_rd_buf_nxt = iwb.iwb_dat;
                    o_if_inst    = iwb.iwb_dat;
                    w_state_nxt  = i_stall[1] ? ST_WAIT_FOR_STALL : ST_IDLE;
                end
            end
            ST_WAIT_FOR_STALL: begin
                o_if_inst = r_rd_buf;
                if (!i_stall[1] || i_flush) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_cyc_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_if_pc     = r_pc;
    assign iwb.iwb_adr = r_adr;
    assign iwb.iwb_cyc = r_cyc;
    assign iwb.iwb_stb = r_cyc;
    assign iwb.iwb_we  = 1'b0;
    assign iwb.iwb_sel = 4'hF;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench: simple ctrl model folds stallreq into stall[0]; instruction memory has programmable wait states.
module tb_inst_fetch_unit;
    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [1:0]  ext_stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch;
    logic [31:0] target;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq;
    logic        ack_en;
    logic [3:0]  wait_states;
    logic [3:0]  wcnt;
    int          checks;
    int          errors;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_new_pc        (new_pc),
        .i_branch_flag   (branch),
        .i_branch_target (target),
        .o_if_pc         (if_pc),
        .o_if_inst       (if_inst),
        .o_stallreq      (stallreq),
        .iwb             (bus.master)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8) return 32'h2402_0005;
        return a ^ 32'h3C00_1234;
    endfunction

    // ctrl: a pending fetch holds the PC
    assign stall = {4'b0000, ext_stall[1], ext_stall[0] | stallreq};

    assign bus.iwb_dat = mem_word(bus.iwb_adr);
    assign bus.iwb_ack = bus.iwb_cyc & bus.iwb_stb & ack_en & (wcnt >= wait_states);

    always @(posedge clk) begin
        if (!bus.iwb_cyc || bus.iwb_ack) wcnt <= 4'd0;
        else                             wcnt <= wcnt + 4'd1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; ext_stall = 2'b00; flush = 1'b0; new_pc = 32'h0;
        branch = 1'b0; target = 32'h0; ack_en = 1'b1; wait_states = 4'd0; wcnt = 4'd0;

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        chk ("rst_if_pc",    if_pc, 32'h0);
        chk ("rst_if_inst",  if_inst, 32'h0);
        chk1("rst_stallreq", stallreq, 1'b0);
        chk1("rst_cyc",      bus.iwb_cyc, 1'b0);
        chk ("rst_adr",      bus.iwb_adr, 32'h0);
        chk1("we_const",     bus.iwb_we, 1'b0);
        chk ("sel_const",    {28'h0, bus.iwb_sel}, 32'hF);

        @(negedge clk); rst = 1'b0; #1;
        chk1("ce0_stallreq", stallreq, 1'b0);
        @(negedge clk); #1;
        chk1("ce1_cyc",      bus.iwb_cyc, 1'b0);
        chk1("ce1_stallreq", stallreq, 1'b1);

        // Zero-wait sequential fetch 0x0, 0x4, 0x8
        @(negedge clk); #1;
        chk ("f0_adr",      bus.iwb_adr, 32'h0);
        chk1("f0_cyc",      bus.iwb_cyc, 1'b1);
        chk1("f0_stb",      bus.iwb_stb, 1'b1);
        chk ("f0_inst",     if_inst, mem_word(32'h0));
        chk1("f0_stallreq", stallreq, 1'b0);
        chk ("f0_pc",       if_pc, 32'h0);
        @(negedge clk); #1;
        chk1("i1_cyc",      bus.iwb_cyc, 1'b0);
        chk1("i1_stallreq", stallreq, 1'b1);
        chk ("i1_pc",       if_pc, 32'h4);
        @(negedge clk); #1;
        chk ("f4_adr",      bus.iwb_adr, 32'h4);
        chk ("f4_inst",     if_inst, mem_word(32'h4));
        @(negedge clk); #1;
        chk1("i2_stallreq", stallreq, 1'b1);

        // IF/ID stall at the ack of 0x24020005
        @(negedge clk); ext_stall = 2'b11; #1;
        chk ("f8_adr",      bus.iwb_adr, 32'h8);
        chk ("f8_inst",     if_inst, 32'h2402_0005);
        chk1("f8_stallreq", stallreq, 1'b0);
        @(negedge clk); #1;
        chk ("w1_inst",     if_inst, 32'h2402_0005);
        chk1("w1_cyc",      bus.iwb_cyc, 1'b0);
        chk1("w1_stallreq", stallreq, 1'b0);
        chk ("w1_pc",       if_pc, 32'h8);
        @(negedge clk); ext_stall = 2'b00; #1;
        chk ("w2_inst",     if_inst, 32'h2402_0005);
        chk1("w2_cyc",      bus.iwb_cyc, 1'b0);
        @(negedge clk); #1;
        chk ("w3_pc",       if_pc, 32'hC);
        chk1("w3_cyc",      bus.iwb_cyc, 1'b0);

        // Flush during BUSY with a same-cycle ack
        @(negedge clk); flush = 1'b1; new_pc = 32'h40; #1;
        chk ("fl_adr",      bus.iwb_adr, 32'hC);
        chk1("fl_ack",      bus.iwb_ack, 1'b1);
        chk ("fl_inst",     if_inst, 32'h0);
        chk1("fl_stallreq", stallreq, 1'b0);
        @(negedge clk); flush = 1'b0; #1;
        chk1("fl_cyc",      bus.iwb_cyc, 1'b0);
        chk ("fl_pc",       if_pc, 32'h40);

        // Taken branch in the ack cycle
        @(negedge clk); branch = 1'b1; target = 32'h100; #1;
        chk ("f40_adr",     bus.iwb_adr, 32'h40);
        chk ("f40_inst",    if_inst, mem_word(32'h40));
        @(negedge clk); branch = 1'b0; #1;
        chk ("br_pc",       if_pc, 32'h100);

        // PC wrap at the top of the address space
        @(negedge clk); flush = 1'b1; new_pc = 32'hFFFF_FFFC; #1;
        chk ("br_adr",      bus.iwb_adr, 32'h100);
        @(negedge clk); flush = 1'b0; #1;
        chk ("top_pc",      if_pc, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        chk ("top_adr",     bus.iwb_adr, 32'hFFFF_FFFC);
        chk ("top_inst",    if_inst, mem_word(32'hFFFF_FFFC));
        @(negedge clk); wait_states = 4'd3; #1;
        chk ("wrap_pc",     if_pc, 32'h0);

        // Three wait states
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk1("ws_stallreq", stallreq, 1'b1);
            chk1("ws_cyc",      bus.iwb_cyc, 1'b1);
            chk ("ws_adr",      bus.iwb_adr, 32'h0);
            chk ("ws_inst",     if_inst, 32'h0);
        end
        @(negedge clk); #1;
        chk1("ws_ack_stallreq", stallreq, 1'b0);
        chk ("ws_ack_inst",     if_inst, mem_word(32'h0));

        // Asynchronous reset in the middle of a bus cycle
        @(negedge clk); ack_en = 1'b0; wait_states = 4'd0; #1;
        chk ("ar_pc",       if_pc, 32'h4);
        @(negedge clk); #1;
        chk1("ar_busy_cyc", bus.iwb_cyc, 1'b1);
        chk ("ar_busy_adr", bus.iwb_adr, 32'h4);
        #2 rst = 1'b1; #1;
        chk1("ar_cyc",      bus.iwb_cyc, 1'b0);
        chk1("ar_stb",      bus.iwb_stb, 1'b0);
        chk ("ar_if_pc",    if_pc, 32'h0);
        chk ("ar_if_inst",  if_inst, 32'h0);
        chk1("ar_stallreq", stallreq, 1'b0);
        @(negedge clk); ack_en = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        chk1("rr_cyc0",     bus.iwb_cyc, 1'b0);
        @(negedge clk); #1;
        chk1("rr_cyc1",     bus.iwb_cyc, 1'b0);
        @(negedge clk); #1;
        chk1("rr_cyc2",     bus.iwb_cyc, 1'b1);
        chk ("rr_adr",      bus.iwb_adr, 32'h0);
        chk ("rr_inst",     if_inst, mem_word(32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
